pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Decode and sequencing controller for the 3-stage MIPS32 datapath (fetch/decode → execute → writeback).
- Latches the instruction on ibus and decodes it into one-hot register-file selects, the ALU op and the immediate controls.
- Delays each control field through pipeline registers so it reaches the datapath in the stage that uses it.
- Also provides pipeline freeze, bubble insertion for illegal opcodes, and an optional forwarding-detect output.

Parameters:
- NREG, 32, number of architectural registers; width of the one-hot selects.
- IW, 32, instruction width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ibus  input  IW  instruction word, stable around the rising edge.
- hold  input  1  freeze: when high, every pipeline register keeps its value.
- Aselect  output  NREG  one-hot source-1 (rs) select, ID stage.
- Bselect  output  NREG  one-hot source-2 select, ID stage (rt for R-format, R0 for I-format).
- Imm  output  1  EX stage: 1 = bbus operand comes from the sign-extended immediate.
- S  output  3  EX stage ALU op: 000 xor, 010 add, 011 sub, 100 or, 110 and.
- Cin  output  1  EX stage ALU carry-in; 1 for sub/subi only.
- Dselect  output  NREG  one-hot write select, WB stage; all-zero means no write.
- illegal  output  1  1-cycle pulse in ID when the latched opcode/funct is undefined.
- fwd_a  output  1  ID: rs matches the EX-stage destination (optional feature).
- fwd_b  output  1  ID: rt matches the EX-stage destination (optional feature).

Behaviour:
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- Decode table:
  - op=000000 R-format, dest=rd; funct 000011 ADD, 000010 SUB, 000001 XOR, 000111 AND, 000100 OR.
  - I-format, dest=rt: op 000011 ADDI, 000010 SUBI, 000001 XORI, 001111 ANDI, 001100 ORI.
  - Any other op or funct is illegal.
- Edge 1: ibus is latched into IF/ID (instr, valid=1). Aselect, Bselect and illegal are decoded combinationally from IF/ID during cycle 2.
- Edge 2: the ID/EX register captures valid, S, Cin, Imm and the destination index. These outputs are driven from ID/EX during cycle 3.
- Edge 3: the EX/WB register captures valid and the destination. Dselect = onehot(dest) during cycle 4 when valid and dest≠0; otherwise all-zero.
- Latency: selects 1 cycle, ALU controls 2 cycles, Dselect 3 cycles after ibus is sampled.
- Throughput: one instruction per cycle when hold=0.
- Writes to R0 are always suppressed (Dselect bit 0 is never set).
- An illegal instruction advances as a bubble:
  - ID/EX valid=0; S=000, Cin=0, Imm=0.
  - The illegal pulse lasts exactly the ID cycle.
- hold=1: IF/ID, ID/EX and EX/WB all retain their values and ibus is ignored; outputs stay constant. illegal stays asserted while an illegal word is held in ID.
- reset=1 (takes priority over hold):
  - All valid bits are cleared; IF/ID instr=0.
  - Aselect=Bselect=onehot(0); S=000, Cin=0, Imm=0, Dselect=0, illegal=0, fwd_a=fwd_b=0.
  - Reset mid-stream discards all in-flight instructions. The first ibus word after reset deasserts gets the normal latency.
- Bselect is onehot(0) for I-format so that the unused bbus reads zero.

Optional Feature:
- Macro: PIPE_CTRL_FWD_EN.
- Defined:
  - fwd_a = IF/ID valid & ID/EX valid & ID/EX dest≠0 & rs==ID/EX dest.
  - fwd_b = the same comparison against rt, R-format only.
  - Both are suppressed while the ID instruction is illegal.
- Undefined: fwd_a and fwd_b are tied to 0 and no comparator logic is generated.

Test Plan:
- Reset then ADDI R1,R0,#0000 (0x0C010000) → next cycle Aselect=0x00000001 and Bselect=0x00000001. +1 cycle: Imm=1, S=010, Cin=0. +1 cycle: Dselect=0x00000002.
- SUBI R31,R21,#0030 followed back-to-back by SUB R13,R0,R0:
  - Aselect=bit21, then bit0.
  - S/Cin=011/1 for both, Imm=1 then 0.
  - Dselect=bit31, then bit13 on consecutive cycles.
- ADDI R0,R0,#FFFF → Dselect stays 0x00000000 throughout its WB cycle.
- Opcode 0x3F word between two ORIs:
  - illegal pulses for 1 cycle.
  - The bubble cycle shows S=000, Imm=0, and Dselect=0 three cycles later.
  - The surrounding ORIs retire normally with S=100, Imm=1.
- hold=1 for 3 cycles mid-stream with XOR R16,R1,R3 in ID → all outputs frozen. Release → Dselect=bit16 arrives 3 pipeline-advancing cycles after fetch.
- With PIPE_CTRL_FWD_EN: ORI R21,R1,#F98B then SUBI R31,R21,#0030 → fwd_a=1 during the SUBI ID cycle. Without the macro fwd_a=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the instruction source / datapath and pipe_ctrl.
// master drives the instruction word and freeze; slave (pipe_ctrl) drives the controls.
interface pipe_ctrl_if #(
    parameter int NREG = 32,
    parameter int IW   = 32
);
    logic [IW-1:0]   ibus;
    logic            hold;
    logic [NREG-1:0] Aselect;
    logic [NREG-1:0] Bselect;
    logic            Imm;
    logic [2:0]      S;
    logic            Cin;
    logic [NREG-1:0] Dselect;
    logic            illegal;
    logic            fwd_a;
    logic            fwd_b;

    modport master (
        output ibus, hold,
        input  Aselect, Bselect, Imm, S, Cin, Dselect, illegal, fwd_a, fwd_b
    );

    modport slave (
        input  ibus, hold,
        output Aselect, Bselect, Imm, S, Cin, Dselect, illegal, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Decode and sequencing controller for a 3-stage MIPS32 datapath (IF/ID -> EX -> WB).
// Define PIPE_CTRL_FWD_EN to generate the rs/rt vs EX-destination forwarding detect.
module pipe_ctrl #(
    parameter int NREG = 32,
    parameter int IW   = 32
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);

    function automatic logic [NREG-1:0] onehot(input logic [4:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic [IW-1:0] if_instr;
    logic          if_valid;

    logic          ex_valid;
    logic [2:0]    ex_s;
    logic          ex_cin;
    logic          ex_imm;
    logic [4:0]    ex_dest;

    logic          wb_valid;
    logic [4:0]    wb_dest;

    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [5:0]    funct;
    logic          is_r;

    logic          dec_legal;
    logic [2:0]    dec_s;
    logic          dec_cin;
    logic          dec_imm;
    logic [4:0]    dec_dest;
    logic          id_ok;

    // shamt bits are never used by this instruction subset
    logic          instr_unused;

    assign op           = if_instr[31:26];
    assign rs           = if_instr[25:21];
    assign rt           = if_instr[20:16];
    assign rd           = if_instr[15:11];
    assign funct        = if_instr[5:0];
    assign is_r         = (op == 6'b000000);
    assign instr_unused = ^if_instr[10:6];

    always_ff @(posedge clk) begin
        if (reset) begin
            if_instr <= '0;
            if_valid <= 1'b0;
        end else if (!bus.hold) begin
            if_instr <= bus.ibus;
            if_valid <= 1'b1;
        end
    end

    always_comb begin
        dec_legal = 1'b0;
        dec_s     = 3'b000;
        dec_cin   = 1'b0;
        dec_imm   = 1'b0;
        dec_dest  = rt;
        if (is_r) begin
            dec_dest = rd;
            case (funct)
                6'b000011: begin dec_legal = 1'b1; dec_s = 3'b010; end
                6'b000010: begin dec_legal = 1'b1; dec_s = 3'b011; dec_cin = 1'b1; end
                6'b000001: begin dec_legal = 1'b1; dec_s = 3'b000; end
                6'b000111: begin dec_legal = 1'b1; dec_s = 3'b110; end
                6'b000100: begin dec_legal = 1'b1; dec_s = 3'b100; end
                default:   dec_legal = 1'b0;
            endcase
        end else begin
            dec_imm = 1'b1;
            case (op)
                6'b000011: begin dec_legal = 1'b1; dec_s = 3'b010; end
                6'b000010: begin dec_legal = 1'b1; dec_s = 3'b011; dec_cin = 1'b1; end
                6'b000001: begin dec_legal = 1'b1; dec_s = 3'b000; end
                6'b001111: begin dec_legal = 1'b1; dec_s = 3'b110; end
                6'b001100: begin dec_legal = 1'b1; dec_s = 3'b100; end
                default:   dec_legal = 1'b0;
            endcase
        end
    end

    assign id_ok       = if_valid & dec_legal;
    assign bus.illegal = if_valid & ~dec_legal;
    assign bus.Aselect = onehot(rs);
    // I-format reads R0 on the B port so the unused bbus is zero
    assign bus.Bselect = is_r ? onehot(rt) : onehot(5'd0);

    // Illegal words travel on as bubbles with neutral ALU controls
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_s     <= 3'b000;
            ex_cin   <= 1'b0;
            ex_imm   <= 1'b0;
            ex_dest  <= 5'd0;
        end else if (!bus.hold) begin
            ex_valid <= id_ok;
            ex_s     <= id_ok ? dec_s    : 3'b000;
            ex_cin   <= id_ok ? dec_cin  : 1'b0;
            ex_imm   <= id_ok ? dec_imm  : 1'b0;
            ex_dest  <= id_ok ? dec_dest : 5'd0;
        end
    end

    assign bus.S   = ex_s;
    assign bus.Cin = ex_cin;
    assign bus.Imm = ex_imm;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_dest  <= 5'd0;
        end else if (!bus.hold) begin
            wb_valid <= ex_valid;
            wb_dest  <= ex_dest;
        end
    end

    assign bus.Dselect = (wb_valid && (wb_dest != 5'd0)) ? onehot(wb_dest) : '0;

`ifdef PIPE_CTRL_FWD_EN
    logic ex_hit;
    assign ex_hit    = ex_valid & (ex_dest != 5'd0);
    assign bus.fwd_a = id_ok & ex_hit & (rs == ex_dest);
    assign bus.fwd_b = id_ok & is_r & ex_hit & (rt == ex_dest);
`else
    assign bus.fwd_a = 1'b0;
    assign bus.fwd_b = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl: a per-cycle table of inputs and expected
// outputs, followed by a randomised hold/R0-write sequence.
module tb_pipe_ctrl;

    logic clk;
    logic reset;

    pipe_ctrl_if #(.NREG(32), .IW(32)) bus ();

    pipe_ctrl #(.NREG(32), .IW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        hld;
        logic [31:0] ib;
        int          a;
        int          b;
        logic        ill;
        logic [2:0]  s;
        logic        cin;
        logic        imm;
        int          d;
        logic        fa;
        logic        fb;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] oh(input int idx);
        logic [31:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input logic rst, input logic hld, input logic [31:0] ib,
                                input int a, input int b, input logic ill,
                                input logic [2:0] s, input logic cin, input logic imm,
                                input int d, input logic fa, input logic fb);
        vec_t v;
        v.rst = rst; v.hld = hld; v.ib = ib;
        v.a = a; v.b = b; v.ill = ill;
        v.s = s; v.cin = cin; v.imm = imm;
        v.d = d; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row %0d got %h expected %h", name, row, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic hld, input logic [31:0] ib);
        reset    = rst;
        bus.hold = hld;
        bus.ibus = ib;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          cur_rs;
        logic [31:0] w;
        logic        h;

        reset    = 1'b1;
        bus.hold = 1'b0;
        bus.ibus = '0;

        //        rst hld ibus           A   B  ill S       cin imm D   fa fb
        vecs.push_back(mk(1, 0, 32'h00000000,  0, 0, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0C010000,  0, 0, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C010000,  0, 0, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0ABF0030, 21, 0, 0, 3'b010, 0, 1, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h00006802,  0, 0, 0, 3'b011, 1, 1,  1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C00FFFF,  0, 0, 0, 3'b011, 1, 0, 31, 0, 0));
        vecs.push_back(mk(0, 0, 32'h3035F98B,  1, 0, 0, 3'b010, 0, 1, 13, 0, 0));
        vecs.push_back(mk(0, 0, 32'hFC000000,  0, 0, 1, 3'b100, 0, 1, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h30620007,  3, 0, 0, 3'b000, 0, 0, 21, 0, 0));
        vecs.push_back(mk(0, 0, 32'h04890005,  4, 0, 0, 3'b100, 0, 1, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h01093807,  8, 9, 0, 3'b000, 0, 1,  2, 0, 1));
        vecs.push_back(mk(0, 0, 32'h00641004,  3, 4, 0, 3'b110, 0, 0,  9, 0, 0));
        vecs.push_back(mk(0, 0, 32'h3C450001,  2, 0, 0, 3'b100, 0, 0,  7, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0023803F,  1, 3, 1, 3'b110, 0, 1,  2, 0, 0));
        vecs.push_back(mk(0, 0, 32'h00A62003,  5, 6, 0, 3'b000, 0, 0,  5, 0, 0));
        vecs.push_back(mk(0, 0, 32'h00000000,  0, 0, 1, 3'b010, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h00000000,  0, 0, 1, 3'b000, 0, 0,  4, 0, 0));
        vecs.push_back(mk(1, 0, 32'h00238001,  0, 0, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h00238001,  1, 3, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0C010000,  1, 3, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0C010000,  1, 3, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0C010000,  1, 3, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C010000,  0, 0, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C00FFFF,  0, 0, 0, 3'b010, 0, 1, 16, 0, 0));
        vecs.push_back(mk(0, 0, 32'hFC000000,  0, 0, 1, 3'b010, 0, 1,  1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0ABF0030,  0, 0, 1, 3'b010, 0, 1,  1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h0ABF0030,  0, 0, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0ABF0030, 21, 0, 0, 3'b000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h3035F98B,  1, 0, 0, 3'b011, 1, 1, -1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0ABF0030, 21, 0, 0, 3'b100, 0, 1, 31, 1, 0));
        vecs.push_back(mk(0, 0, 32'h00006802,  0, 0, 0, 3'b011, 1, 1, 21, 0, 0));
        vecs.push_back(mk(0, 0, 32'h00A62003,  5, 6, 0, 3'b011, 1, 0, 31, 0, 0));
        vecs.push_back(mk(0, 0, 32'h00000000,  0, 0, 1, 3'b010, 0, 0, 13, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].hld, vecs[i].ib);
            chk("Aselect", i, bus.Aselect, oh(vecs[i].a));
            chk("Bselect", i, bus.Bselect, oh(vecs[i].b));
            chk("illegal", i, {31'd0, bus.illegal}, {31'd0, vecs[i].ill});
            chk("S",       i, {29'd0, bus.S},       {29'd0, vecs[i].s});
            chk("Cin",     i, {31'd0, bus.Cin},     {31'd0, vecs[i].cin});
            chk("Imm",     i, {31'd0, bus.Imm},     {31'd0, vecs[i].imm});
            chk("Dselect", i, bus.Dselect,          oh(vecs[i].d));
            chk("fwd_a",   i, {31'd0, bus.fwd_a},   {31'd0, FWD & vecs[i].fa});
            chk("fwd_b",   i, {31'd0, bus.fwd_b},   {31'd0, FWD & vecs[i].fb});
        end

        // Random stream of ADDI R0,Rx,#imm with random freezes: no write may ever
        // reach R0, and the A select must track the last word actually latched.
        step(1'b1, 1'b0, 32'h0);
        cur_rs = 0;
        for (int k = 0; k < 40; k++) begin
            int rsv;
            rsv = int'($urandom_range(31, 0));
            w   = {6'b000011, rsv[4:0], 5'd0, 16'($urandom)};
            h   = 1'($urandom_range(1, 0));
            step(1'b0, h, w);
            if (!h) cur_rs = rsv;
            chk("r0_Aselect", 100 + k, bus.Aselect, oh(cur_rs));
            chk("r0_Bselect", 100 + k, bus.Bselect, oh(0));
            chk("r0_Dselect", 100 + k, bus.Dselect, 32'h0);
            chk("r0_illegal", 100 + k, {31'd0, bus.illegal}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
